freq_window_monitor: RTL and testbench
======================================

FREQ_WINDOW_MONITOR -- requirements
Module: freq_window_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent measured channels (1..32).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the window length.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of each channel edge counter and threshold.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin measurement.
REQ-007 SHALL have port stop, input, 1, abort a running measurement.
REQ-008 SHALL have port continuous, input, 1, 1 = back-to-back windows, 0 = one-shot.
REQ-009 SHALL have port window_value, input, DATA_WIDTH, window length in clk cycles.
REQ-010 SHALL have port ch_tick, input, NUM_CH, per-channel edge pulses already synchronous to clk.
REQ-011 SHALL have port thresh_lo, input, NUM_CH*CNT_WIDTH, per-channel lower bound with channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-012 SHALL have port thresh_hi, input, NUM_CH*CNT_WIDTH, per-channel upper bound using the same packing as thresh_lo.
REQ-013 SHALL have port ch_count, output, NUM_CH*CNT_WIDTH, last completed window count per channel.
REQ-014 SHALL have ports too_low, too_high, in_range and overflow, each output, NUM_CH, per-channel result flags.
REQ-015 SHALL have port busy, output, 1, high outside IDLE.
REQ-016 SHALL have port done, output, 1, single-cycle result-valid pulse.

Function
REQ-017 SHALL implement FSM states IDLE, COUNT and EVAL.
REQ-018 IDLE SHALL go to COUNT on start=1 with window_value!=0; start with window_value==0 SHALL be ignored.
REQ-019 Entering COUNT SHALL load the window timer with window_value and clear all channel counters.
REQ-020 Window_value SHALL be sampled only at window load and never re-read mid-window.
REQ-021 Each channel counter SHALL increment in every COUNT cycle in which its ch_tick bit is 1.
REQ-022 COUNT SHALL last exactly window_value cycles, with the timer decrementing each cycle and COUNT going to EVAL when the timer equals 1.
REQ-023 A channel counter SHALL saturate at all-ones, and that channel's sticky internal overflow bit SHALL set for the window.
REQ-024 In EVAL (one cycle), the channel count SHALL be compared against thresholds sampled in that cycle: too_low = count < lo, too_high = count > hi, in_range = neither, unsigned compare.
REQ-025 When thresh_lo > thresh_hi, too_low and too_high SHALL both assert where both compares hold, and in_range SHALL be 0.
REQ-026 ch_count, flags and overflow SHALL be registered at the end of EVAL, valid from the next cycle, and held until the next EVAL.
REQ-027 done SHALL pulse exactly 1 cycle, coincident with the first cycle the new results are visible.
REQ-028 Latency SHALL be: start accepted at cycle 0, ticks counted in cycles 1..W, EVAL at cycle W+1, done and results at cycle W+2.
REQ-029 With continuous=1 at EVAL, the FSM SHALL go to COUNT, reload window_value, and load each counter with that channel's EVAL-cycle ch_tick value, so no tick is lost between windows.
REQ-030 With continuous=0 at EVAL, the FSM SHALL go to IDLE, and EVAL-cycle ticks SHALL be discarded.
REQ-031 stop=1 in COUNT or EVAL SHALL force IDLE next cycle with no done and no result update; stop SHALL have priority over the EVAL transition.
REQ-032 stop in IDLE SHALL have no effect, and start while busy SHALL be ignored.
REQ-033 Simultaneous start and stop in IDLE SHALL cause no transition (stop wins).
REQ-034 busy SHALL equal (state != IDLE).

Reset
REQ-035 reset=1 SHALL asynchronously force IDLE, timer 0, all counters 0, ch_count 0, too_low/too_high/in_range/overflow 0, busy 0 and done 0.
REQ-036 Reset mid-window SHALL discard the partial window, with no done pulse after reset release.
REQ-037 After reset release, the first start SHALL behave per REQ-018.

Verification
REQ-038 NUM_CH=2, W=10, ch0 tick every cycle, ch1 every 3rd cycle, lo=5, hi=8, one-shot -> done at cycle 12; ch_count0=10 too_high=1; ch_count1=3 or 4 (phase-dependent) too_low=1.
REQ-039 CNT_WIDTH=4, W=20, ch0 ticking every cycle -> ch_count0=15, overflow0=1, too_high per hi=14.
REQ-040 continuous=1, W=5, ch0 tick every cycle incl. EVAL -> done every 6 cycles; first count 5, subsequent counts 6 (EVAL tick carried).
REQ-041 stop asserted at cycle 4 of W=10 -> busy low next cycle, no done, previous results unchanged; start with window_value=0 -> busy stays 0.
REQ-042 reset pulsed mid-COUNT -> all outputs 0 immediately, no done afterwards; thresh_lo=9 > thresh_hi=3 with count 6 -> too_low=1, too_high=1, in_range=0.

Source files
------------

// File: rtl/freq_window_monitor.sv
// Multi-channel frequency window monitor: counts per-channel edge ticks over a
// programmable window of clk cycles and classifies each count against thresholds.
module freq_window_monitor #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          continuous,
  input  logic [DATA_WIDTH-1:0]         window_value,
  input  logic [NUM_CH-1:0]             ch_tick,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   thresh_lo,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   thresh_hi,
  output logic [NUM_CH*CNT_WIDTH-1:0]   ch_count,
  output logic [NUM_CH-1:0]             too_low,
  output logic [NUM_CH-1:0]             too_high,
  output logic [NUM_CH-1:0]             in_range,
  output logic [NUM_CH-1:0]             overflow,
  output logic                          busy,
  output logic                          done
);

  // state | meaning
  // IDLE  | waiting for start with a non-zero window
  // COUNT | window timer running, channel counters accumulating ticks
  // EVAL  | one cycle: compare counts, register results, reload or stop
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]                          state;
  logic [DATA_WIDTH-1:0]               timer;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    cnt;
  logic [NUM_CH-1:0]                   ovf;
  logic [NUM_CH-1:0]                   lt;
  logic [NUM_CH-1:0]                   gt;

  always_comb begin
    lt = '0;
    gt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lt[i] = cnt[i] < thresh_lo[i*CNT_WIDTH +: CNT_WIDTH];
      gt[i] = cnt[i] > thresh_hi[i*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      cnt      <= '0;
      ovf      <= '0;
      ch_count <= '0;
      too_low  <= '0;
      too_high <= '0;
      in_range <= '0;
      overflow <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop && (window_value != '0)) begin
            state <= S_COUNT;
            timer <= window_value;
            cnt   <= '0;
            ovf   <= '0;
          end
        end
        S_COUNT: begin
          if (stop) begin
            state <= S_IDLE;
          end else begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (ch_tick[i]) begin
                if (cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
                else                   cnt[i] <= cnt[i] + CNT_WIDTH'(1);
              end
            end
            timer <= timer - DATA_WIDTH'(1);
            if (timer == DATA_WIDTH'(1)) state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (stop) begin
            state <= S_IDLE;
          end else begin
            ch_count <= cnt;
            too_low  <= lt;
            too_high <= gt;
            in_range <= ~lt & ~gt;
            overflow <= ovf;
            done     <= 1'b1;
            // EVAL-cycle ticks seed the next window so back-to-back windows lose nothing
            if (continuous && (window_value != '0)) begin
              state <= S_COUNT;
              timer <= window_value;
              ovf   <= '0;
              for (int i = 0; i < NUM_CH; i++) cnt[i] <= CNT_WIDTH'(ch_tick[i]);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_window_monitor.sv
// Directed self-checking bench for freq_window_monitor (2 channels, 4-bit counters).
module tb_freq_window_monitor;
  localparam int NUM_CH = 2;
  localparam int DW     = 16;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              continuous = 1'b0;
  logic [DW-1:0]     window_value = '0;
  logic [NUM_CH-1:0] ch_tick = '0;
  logic [NUM_CH*CW-1:0] thresh_lo = '0;
  logic [NUM_CH*CW-1:0] thresh_hi = '0;
  logic [NUM_CH*CW-1:0] ch_count;
  logic [NUM_CH-1:0] too_low, too_high, in_range, overflow;
  logic              busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  freq_window_monitor #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .window_value(window_value), .ch_tick(ch_tick), .thresh_lo(thresh_lo),
    .thresh_hi(thresh_hi), .ch_count(ch_count), .too_low(too_low), .too_high(too_high),
    .in_range(in_range), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({ch_count, too_low, too_high, in_range, overflow, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs act=%h exp=0", {ch_count, too_low, too_high, in_range, overflow, busy, done});
    end
    reset = 1'b0;
    cyc();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy act=%b exp=0", busy); end
  endtask

  // W=10, ch0 every cycle, ch1 on window cycles 3,6,9; window_value changed mid-window
  task automatic test_basic();
    thresh_lo = {4'd5, 4'd5};
    thresh_hi = {4'd8, 4'd8};
    window_value = 16'd10;
    ch_tick = 2'b01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    window_value = 16'd3;
    for (int j = 1; j <= 10; j++) begin
      ch_tick[1] = (j % 3 == 0);
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL basic_count_phase cyc=%0d busy=%b done=%b exp busy=1 done=0", j, busy, done);
      end
      cyc();
    end
    ch_tick = 2'b00;
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_eval_cycle busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    cyc();
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done_c12 act=%b exp=1", done); end
    n_chk++;
    if (ch_count !== {4'd3, 4'd10}) begin n_fail++; $display("FAIL basic_count act=%h exp=3a", ch_count); end
    n_chk++;
    if ({too_low, too_high, in_range} !== {2'b10, 2'b01, 2'b00}) begin
      n_fail++; $display("FAIL basic_flags lo=%b hi=%b ir=%b exp lo=10 hi=01 ir=00", too_low, too_high, in_range);
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after act=%b exp=0", busy); end
    cyc();
    n_chk++;
    if (done !== 1'b0 || ch_count !== {4'd3, 4'd10}) begin
      n_fail++; $display("FAIL basic_hold done=%b count=%h exp done=0 count=3a", done, ch_count);
    end
  endtask

  task automatic test_overflow();
    thresh_lo = {4'd5, 4'd5};
    thresh_hi = {4'd14, 4'd14};
    window_value = 16'd20;
    ch_tick = 2'b01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (21) cyc();
    ch_tick = 2'b00;
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL ovf_done act=%b exp=1", done); end
    n_chk++;
    if (ch_count !== {4'd0, 4'd15}) begin n_fail++; $display("FAIL ovf_count act=%h exp=0f", ch_count); end
    n_chk++;
    if (overflow !== 2'b01) begin n_fail++; $display("FAIL ovf_flag act=%b exp=01", overflow); end
    n_chk++;
    if (too_high !== 2'b01 || too_low !== 2'b10) begin
      n_fail++; $display("FAIL ovf_flags hi=%b lo=%b exp hi=01 lo=10", too_high, too_low);
    end
  endtask

  // counts exactly on lo (ch1) and exactly on hi (ch0) are in range
  task automatic test_in_range();
    thresh_lo = {4'd5, 4'd5};
    thresh_hi = {4'd7, 4'd7};
    window_value = 16'd7;
    ch_tick = 2'b01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      ch_tick[1] = (j <= 5);
      cyc();
    end
    ch_tick = 2'b00;
    cyc();
    n_chk++;
    if (done !== 1'b1 || ch_count !== {4'd5, 4'd7}) begin
      n_fail++; $display("FAIL inr_count done=%b count=%h exp done=1 count=57", done, ch_count);
    end
    n_chk++;
    if ({in_range, too_low, too_high, overflow} !== {2'b11, 2'b00, 2'b00, 2'b00}) begin
      n_fail++; $display("FAIL inr_flags ir=%b lo=%b hi=%b ovf=%b exp ir=11 others 00", in_range, too_low, too_high, overflow);
    end
  endtask

  task automatic test_continuous();
    thresh_lo = {4'd5, 4'd5};
    thresh_hi = {4'd8, 4'd8};
    window_value = 16'd5;
    continuous = 1'b1;
    ch_tick = 2'b01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      n_chk++;
      if (done !== (c == 7 || c == 13 || c == 19)) begin
        n_fail++; $display("FAIL cont_done_timing cyc=%0d act=%b", c, done);
      end
      if (c == 7) begin
        n_chk++;
        if (ch_count[3:0] !== 4'd5) begin n_fail++; $display("FAIL cont_first_count act=%0d exp=5", ch_count[3:0]); end
      end
      if (c == 13 || c == 19) begin
        n_chk++;
        if (ch_count[3:0] !== 4'd6) begin n_fail++; $display("FAIL cont_carry_count cyc=%0d act=%0d exp=6", c, ch_count[3:0]); end
      end
      if (c < 19) cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    continuous = 1'b0;
    ch_tick = 2'b00;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || ch_count[3:0] !== 4'd6) begin
      n_fail++; $display("FAIL cont_stop busy=%b done=%b count=%0d exp 0 0 6", busy, done, ch_count[3:0]);
    end
  endtask

  task automatic test_stop();
    bit seen_done = 0;
    window_value = 16'd10;
    ch_tick = 2'b01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || ch_count[3:0] !== 4'd6) begin
      n_fail++; $display("FAIL stop_abort busy=%b done=%b count=%0d exp 0 0 6", busy, done, ch_count[3:0]);
    end
    for (int j = 0; j < 15; j++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
      cyc();
    end
    n_chk++;
    if (seen_done) begin n_fail++; $display("FAIL stop_no_done act=activity exp=none"); end
    window_value = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_window busy=%b exp=0", busy); end
    window_value = 16'd5;
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_idle busy=%b exp=0", busy); end
    ch_tick = 2'b00;
  endtask

  // start pulses while busy must not restart or reload the window
  task automatic test_back_to_back();
    window_value = 16'd4;
    ch_tick = 2'b01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    window_value = 16'd9;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    ch_tick = 2'b00;
    cyc();
    n_chk++;
    if (done !== 1'b1 || ch_count[3:0] !== 4'd4) begin
      n_fail++; $display("FAIL busy_start_ignored done=%b count=%0d exp done=1 count=4", done, ch_count[3:0]);
    end
  endtask

  task automatic test_reset_inverted();
    bit seen = 0;
    thresh_lo = {4'd9, 4'd9};
    thresh_hi = {4'd3, 4'd3};
    window_value = 16'd6;
    ch_tick = 2'b01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    ch_tick = 2'b00;
    n_chk++;
    if (done !== 1'b1 || ch_count !== {4'd0, 4'd6}) begin
      n_fail++; $display("FAIL inv_count done=%b count=%h exp done=1 count=06", done, ch_count);
    end
    n_chk++;
    if ({too_low, too_high, in_range} !== {2'b11, 2'b01, 2'b00}) begin
      n_fail++; $display("FAIL inv_flags lo=%b hi=%b ir=%b exp lo=11 hi=01 ir=00", too_low, too_high, in_range);
    end
    window_value = 16'd10;
    ch_tick = 2'b11;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    n_chk++;
    if ({ch_count, too_low, too_high, in_range, overflow, busy, done} !== '0) begin
      n_fail++; $display("FAIL async_reset act=%h exp=0", {ch_count, too_low, too_high, in_range, overflow, busy, done});
    end
    #1;
    reset = 1'b0;
    cyc();
    for (int j = 0; j < 15; j++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1;
      cyc();
    end
    n_chk++;
    if (seen) begin n_fail++; $display("FAIL reset_no_done act=activity exp=none"); end
    window_value = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_zero_start busy=%b exp=0", busy); end
    window_value = 16'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL post_reset_start busy=%b exp=1", busy); end
    cyc();
    cyc();
    ch_tick = 2'b00;
    cyc();
    n_chk++;
    if (done !== 1'b1 || ch_count !== {4'd2, 4'd2}) begin
      n_fail++; $display("FAIL post_reset_window done=%b count=%h exp done=1 count=22", done, ch_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_in_range();
    test_continuous();
    test_stop();
    test_back_to_back();
    test_reset_inverted();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
